// File: rtl/fxp_dense_layer_stream.sv
// Fully-connected layer y[j] = act(sum_i x[i]*W[i][j] + b[j]) over a streamed bias/weight sequence.
// Latency: N_IN+1 accepted stream beats plus one EMIT cycle per neuron; done pulses after the last result.
// Backpressure: w_ready drops while a result waits on y_ready; w_valid gaps stall the MAC in place.
module fxp_dense_layer_stream #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 50,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] x [N_IN],
  output logic              busy,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [DATA_W-1:0] y_data,
  output logic [IDX_W-1:0]  y_index,
  output logic              done,
  output logic [IDX_W-1:0]  max_index,
  output logic [DATA_W-1:0] max_value
);

  localparam int XI_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(N_IN+1) + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ROUND  = ACC_W'(1) << (FRAC_W-1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_EMIT, S_DONE} state_t;

  state_t                    state, state_nxt;
  logic [DATA_W-1:0]         x_reg [N_IN];
  logic                      mode_r;
  logic signed [ACC_W-1:0]   acc, acc_nxt, rnd, shf;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]         res;
  logic                      first;   // next beat of this neuron is its bias
  logic [XI_W-1:0]           xi;      // index of the next weight within the neuron
  logic [IDX_W-1:0]          j;
  logic                      last_beat;

  assign last_beat = (state == S_MAC) && w_valid && !first && (xi == XI_W'(N_IN-1));
  assign y_index   = j;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_MAC;
      S_MAC:   if (last_beat) state_nxt = S_EMIT;
      S_EMIT:  if (y_ready) state_nxt = (j == IDX_W'(N_OUT-1)) ? S_DONE : S_MAC;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    busy    = (state != S_IDLE);
    w_ready = (state == S_MAC);
    y_valid = (state == S_EMIT);
    done    = (state == S_DONE);
  end

  // Accumulator value after the beat currently on w_data: bias load or multiply-accumulate
  always_comb begin
    prod    = $signed(x_reg[xi]) * $signed(w_data);
    acc_nxt = acc;
    if (first) acc_nxt = {{(ACC_W-DATA_W-FRAC_W){w_data[DATA_W-1]}}, w_data, {FRAC_W{1'b0}}};
    else       acc_nxt = acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  // Round half up, saturate to the data range, then optional ReLU
  always_comb begin
    rnd = acc_nxt + ROUND;
    shf = rnd >>> FRAC_W;
    if (shf > SAT_HI)      res = SAT_HI[DATA_W-1:0];
    else if (shf < SAT_LO) res = SAT_LO[DATA_W-1:0];
    else                   res = shf[DATA_W-1:0];
    if (mode_r && res[DATA_W-1]) res = '0;
  end

  // Datapath: capture inputs, run the MAC, hold the result, track the argmax
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_IN; i++) x_reg[i] <= '0;
      mode_r    <= 1'b0;
      acc       <= '0;
      first     <= 1'b1;
      xi        <= '0;
      j         <= '0;
      y_data    <= '0;
      max_index <= '0;
      max_value <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          x_reg     <= x;
          mode_r    <= mode;
          acc       <= '0;
          first     <= 1'b1;
          xi        <= '0;
          j         <= '0;
          max_index <= '0;
          max_value <= '0;
        end
        S_MAC: if (w_valid) begin
          acc <= acc_nxt;
          if (first) begin
            first <= 1'b0;
            xi    <= '0;
          end else if (last_beat) begin
            y_data <= res;
            xi     <= '0;
          end else begin
            xi <= xi + XI_W'(1);
          end
        end
        S_EMIT: if (y_ready) begin
          // Strictly-greater update keeps the lowest index on ties
          if ((j == '0) || ($signed(y_data) > $signed(max_value))) begin
            max_index <= j;
            max_value <= y_data;
          end
          if (j != IDX_W'(N_OUT-1)) begin
            j     <= j + IDX_W'(1);
            first <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fxp_dense_layer_stream.md
Name: fxp_dense_layer_stream

Overview:
- Parametrised successor to the fixed-array prediction core: computes one fully-connected layer y[j] = act(sum_i x[i]*W[i][j] + b[j]) in signed fixed point with configurable width and fraction.
- Weights and biases are streamed via valid/ready instead of full-array ports, so layer size is no longer bounded by port width.
- Results leave as a handshaked stream; the running argmax is reported at completion.
- Layers are chained by the network controller.

Parameters:
N_IN, 784, number of inputs per output neuron (>=1)
N_OUT, 50, number of output neurons (>=1)
DATA_W, 16, signed width of x, weights, bias, y
FRAC_W, 10, fractional bits of all data words (1 <= FRAC_W < DATA_W)

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
start  input  1  begin layer; sampled only in IDLE
mode  input  1  0 = linear, 1 = ReLU; sampled with start
x  input  [N_IN] x DATA_W  unpacked input vector; captured on accepted start
busy  output  1  high from accepted start until the DONE cycle inclusive
w_valid  input  1  weight/bias word valid
w_ready  output  1  block can accept w_data
w_data  input  DATA_W  bias or weight word
y_valid  output  1  result available
y_ready  input  1  downstream accepts result
y_data  output  DATA_W  activated, saturated result
y_index  output  clog2(N_OUT) (min 1)  neuron index of y_data
done  output  1  one-cycle pulse after last result accepted
max_index  output  clog2(N_OUT) (min 1)  argmax of emitted results; valid when done, held until next start
max_value  output  DATA_W  value at max_index

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, w_ready, y_valid, done = 0; y_data, y_index, max_index, max_value = 0; accumulator and counters cleared.
- Reset mid-operation aborts immediately. Partial sums and captured x are discarded. The upstream stream position is the controller's concern.
- States:
  - IDLE: on start=1, latch x and mode, clear j and argmax, go to MAC. start is ignored when not in IDLE.
  - MAC: w_ready=1. Stream order per neuron j is bias b[j] first, then W[0][j]..W[N_IN-1][j]. Total stream length is N_OUT*(N_IN+1) words.
    - On the bias beat: acc = sign-extend(b) << FRAC_W.
    - On weight beat i: acc += x[i]*w_data (full 2*DATA_W product).
    - After the (N_IN+1)-th accepted beat, go to EMIT next cycle.
  - EMIT: w_ready=0, y_valid=1. y_data and y_index are stable until y_valid&&y_ready.
    - On handshake, update argmax. If j==N_OUT-1 go to DONE, else j++ and go to MAC.
  - DONE: done=1 for exactly one cycle, busy still 1, then IDLE.
- Arithmetic:
  - Accumulator width ACC_W = 2*DATA_W + clog2(N_IN+1) + 1. It never overflows.
  - Result r = (acc + 2^(FRAC_W-1)) >>> FRAC_W, i.e. round half toward +inf.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If mode=1 and r<0, r=0.
- Argmax: compares post-activation signed values. A candidate replaces the current max only if strictly greater, so ties keep the lowest index. Neuron 0 always initialises the max.
- Throughput: one stream beat per cycle when w_valid stays high. Minimum N_IN+2 cycles per neuron with y_ready held high. A w_valid gap stalls MAC without changing the accumulator.
- y_ready is ignored outside EMIT. w_valid is ignored while w_ready=0.

Test Plan (N_IN=4, N_OUT=3, DATA_W=16, FRAC_W=8):
- Basic, mode=0, x={0x0100,0x0200,0xFF00,0x0080}:
  - Stream for j0: 0x0080 then 4x 0x0100 -> y0=0x0300.
  - Stream for j1: 0x0000 then 4x 0xFF00 -> y1=0xFD80.
  - Stream for j2: 0x0000 then 4x 0x7F00 -> y2=0x7FFF (saturated).
  - Then done pulse, max_index=2, max_value=0x7FFF, y_index 0,1,2 in order.
- ReLU, same stimulus with mode=1 -> y1=0x0000, y0 and y2 unchanged. Verify the negative-saturation path separately: all weights 0x8000 with x0=0x7FFF, mode=0 -> y=0x8000.
- Rounding, x={0x0001,0,0,0}:
  - w0=0x0080, bias 0 -> y=0x0001.
  - x0=0xFFFF with same weights -> y=0x0000.
- Backpressure and gaps: hold y_ready=0 for 5 cycles in EMIT -> y_valid, y_data, y_index stable and w_ready=0. Insert w_valid gaps -> results identical to the gap-free run.
- Ties: all outputs 0x0100 -> max_index=0. Assert start while busy -> ignored, results unchanged.
- Reset mid-MAC: drop rstn after 2 weight beats -> busy, w_ready, y_valid go to 0 immediately. A subsequent full run reproduces the basic-case values exactly.
